interp_upconvert: RTL and testbench

- Transmit-side counterpart of the receive decimator. Accepts baseband I/Q samples at the low rate through a valid/ready handshake and buffers them in a small FIFO.
- Interpolates by INTERP with a 2nd-order CIC interpolator, then mixes with externally supplied NCO sin/cos. The NCO is the shared sg generator, driven by its own tune word.
- Output is I*cos - Q*sin, rounded and saturated to a 14-bit DAC word every dac_clk.

---
 rtl/interp_upconvert.sv | 264 ++++++++++++++++++++++++++
 tb/tb_interp_upconvert.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interp_upconvert.sv
// interp_upconvert
// Transmit-side upconverter: buffers low-rate baseband I/Q in a small FIFO,
// interpolates by INTERP with a 2nd-order CIC, mixes with external NCO
// sin/cos and emits I*cos - Q*sin as a rounded, saturated 14-bit DAC word.
// Build option: define DAC_OFFSET_BINARY_EN for offset-binary dac_data.
// Without it, dac_data is two's complement.

module interp_upconvert #(
   parameter int INTERP     = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int PRIME      = 2
) (
   input  logic               dac_clk,
   input  logic               reset_n,
   input  logic signed [23:0] in_i,
   input  logic signed [23:0] in_q,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [19:0] nco_sin,
   input  logic signed [19:0] nco_cos,
   output logic [13:0]        dac_data,
   output logic               running,
   output logic [15:0]        underrun_cnt
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);
   localparam logic [OCC_W-1:0] PRIME_OCC = OCC_W'(PRIME);
   localparam logic [1:0]       RATE_LOAD = 2'(INTERP - 1);

   localparam logic signed [27:0] SAT26_MAX  = 28'sd33554431;
   localparam logic signed [27:0] SAT26_MIN  = -28'sd33554432;
   localparam logic signed [46:0] ROUND_HALF = 47'sd1073741824;
   localparam logic signed [46:0] DAC_MAX    = 47'sd8191;
   localparam logic signed [46:0] DAC_MIN    = -47'sd8192;

`ifdef DAC_OFFSET_BINARY_EN
   localparam logic [13:0] DAC_RESET = 14'h2000;
`else
   localparam logic [13:0] DAC_RESET = 14'h0000;
`endif

   // FIFO state
   logic signed [23:0] mem_i_q [FIFO_DEPTH];
   logic signed [23:0] mem_i_d [FIFO_DEPTH];
   logic signed [23:0] mem_q_q [FIFO_DEPTH];
   logic signed [23:0] mem_q_d [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]   occ_q, occ_d;
   logic               in_ready_q, in_ready_d;

   // control state
   logic               running_q, running_d;
   logic [1:0]         rate_cnt_q, rate_cnt_d;
   logic [15:0]        underrun_cnt_q, underrun_cnt_d;

   // S0 popped sample and S1 combs
   logic signed [23:0] x_i_q, x_i_d, x_q_q, x_q_d;
   logic signed [23:0] xd_i_q, xd_i_d, xd_q_q, xd_q_d;
   logic signed [25:0] comb1_i_q, comb1_i_d, comb1_q_q, comb1_q_d;
   logic signed [25:0] comb2_i_q, comb2_i_d, comb2_q_q, comb2_q_d;
   logic               pop_s0_q, pop_s0_d;
   logic               pop_s1_q, pop_s1_d;

   // S2/S3 integrators
   logic signed [25:0] integ_in_i, integ_in_q;
   logic signed [27:0] integ1_i_q, integ1_i_d, integ1_q_q, integ1_q_d;
   logic signed [27:0] integ2_i_q, integ2_i_d, integ2_q_q, integ2_q_d;

   // S4..S6 mixer and output
   logic signed [25:0] sat_i_q, sat_i_d, sat_q_q, sat_q_d;
   logic signed [19:0] sin_q, sin_d, cos_q, cos_d;
   logic signed [45:0] prod_i_q, prod_i_d, prod_q_q, prod_q_d;
   logic signed [46:0] mix_sum, mix_round, mix_scaled;
   logic signed [13:0] dac_word;
   logic [13:0]        dac_q, dac_d;

   logic push, pop, pop_take, starve;

   assign push     = in_valid && in_ready_q;
   assign pop      = running_q && (rate_cnt_q == 2'd0);
   assign pop_take = pop && (occ_q != '0);
   assign starve   = pop && (occ_q == '0);

   assign in_ready     = in_ready_q;
   assign running      = running_q;
   assign underrun_cnt = underrun_cnt_q;
   assign dac_data     = dac_q;

   function automatic logic signed [25:0] sat26(input logic signed [27:0] v);
      if (v > SAT26_MAX)      sat26 = {1'b0, {25{1'b1}}};
      else if (v < SAT26_MIN) sat26 = {1'b1, 25'd0};
      else                    sat26 = v[25:0];
   endfunction

   // FIFO write/read pointers, occupancy and the registered ready flag
   always_comb begin
      mem_i_d  = mem_i_q;
      mem_q_d  = mem_q_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) begin
         mem_i_d[wr_ptr_q] = in_i;
         mem_q_d[wr_ptr_q] = in_q;
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      if (pop_take) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop_take})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
      in_ready_d = (occ_d != DEPTH_OCC);
   end

   // Sticky start flag, output-rate counter and saturating starvation count
   always_comb begin
      running_d      = running_q || (occ_q >= PRIME_OCC);
      rate_cnt_d     = rate_cnt_q;
      underrun_cnt_d = underrun_cnt_q;
      if (running_q) begin
         rate_cnt_d = (rate_cnt_q == 2'd0) ? RATE_LOAD : rate_cnt_q - 2'd1;
      end
      if (starve && (underrun_cnt_q != 16'hFFFF)) begin
         underrun_cnt_d = underrun_cnt_q + 16'd1;
      end
   end

   // Capture the popped sample (zeros when starved) and run the combs once per pop
   always_comb begin
      x_i_d     = x_i_q;
      x_q_d     = x_q_q;
      xd_i_d    = xd_i_q;
      xd_q_d    = xd_q_q;
      comb1_i_d = comb1_i_q;
      comb1_q_d = comb1_q_q;
      comb2_i_d = comb2_i_q;
      comb2_q_d = comb2_q_q;
      pop_s0_d  = pop;
      pop_s1_d  = pop_s0_q;
      if (pop) begin
         x_i_d = pop_take ? mem_i_q[rd_ptr_q] : 24'sd0;
         x_q_d = pop_take ? mem_q_q[rd_ptr_q] : 24'sd0;
      end
      if (pop_s0_q) begin
         xd_i_d    = x_i_q;
         xd_q_d    = x_q_q;
         comb1_i_d = 26'(x_i_q) - 26'(xd_i_q);
         comb1_q_d = 26'(x_q_q) - 26'(xd_q_q);
         comb2_i_d = comb1_i_d - comb1_i_q;
         comb2_q_d = comb1_q_d - comb1_q_q;
      end
   end

   // Zero-stuff the comb output and accumulate every clock (wrap is intended)
   always_comb begin
      integ_in_i = pop_s1_q ? comb2_i_q : 26'sd0;
      integ_in_q = pop_s1_q ? comb2_q_q : 26'sd0;
      integ1_i_d = integ1_i_q + 28'(integ_in_i);
      integ1_q_d = integ1_q_q + 28'(integ_in_q);
      integ2_i_d = integ2_i_q + integ1_i_q;
      integ2_q_d = integ2_q_q + integ1_q_q;
   end

   // Saturate the CIC output, register the NCO and form the mixer products
   always_comb begin
      sat_i_d  = sat26(integ2_i_q);
      sat_q_d  = sat26(integ2_q_q);
      sin_d    = nco_sin;
      cos_d    = nco_cos;
      prod_i_d = 46'(sat_i_q) * 46'(cos_q);
      prod_q_d = 46'(sat_q_q) * 46'(sin_q);
   end

   // Combine I*cos - Q*sin, round to nearest, saturate to the 14-bit DAC range
   always_comb begin
      mix_sum    = 47'(prod_i_q) - 47'(prod_q_q);
      mix_round  = mix_sum + ROUND_HALF;
      mix_scaled = mix_round >>> 31;
      if (mix_scaled > DAC_MAX)      dac_word = 14'sh1FFF;
      else if (mix_scaled < DAC_MIN) dac_word = 14'sh2000;
      else                           dac_word = mix_scaled[13:0];
`ifdef DAC_OFFSET_BINARY_EN
      dac_d = {~dac_word[13], dac_word[12:0]};
`else
      dac_d = dac_word;
`endif
   end

   // All state registers with synchronous active-low clear
   always_ff @(posedge dac_clk) begin
      if (!reset_n) begin
         for (int k = 0; k < FIFO_DEPTH; k++) begin
            mem_i_q[k] <= '0;
            mem_q_q[k] <= '0;
         end
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         occ_q          <= '0;
         in_ready_q     <= 1'b0;
         running_q      <= 1'b0;
         rate_cnt_q     <= RATE_LOAD;
         underrun_cnt_q <= '0;
         x_i_q          <= '0;
         x_q_q          <= '0;
         xd_i_q         <= '0;
         xd_q_q         <= '0;
         comb1_i_q      <= '0;
         comb1_q_q      <= '0;
         comb2_i_q      <= '0;
         comb2_q_q      <= '0;
         pop_s0_q       <= 1'b0;
         pop_s1_q       <= 1'b0;
         integ1_i_q     <= '0;
         integ1_q_q     <= '0;
         integ2_i_q     <= '0;
         integ2_q_q     <= '0;
         sat_i_q        <= '0;
         sat_q_q        <= '0;
         sin_q          <= '0;
         cos_q          <= '0;
         prod_i_q       <= '0;
         prod_q_q       <= '0;
         dac_q          <= DAC_RESET;
      end else begin
         mem_i_q        <= mem_i_d;
         mem_q_q        <= mem_q_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         occ_q          <= occ_d;
         in_ready_q     <= in_ready_d;
         running_q      <= running_d;
         rate_cnt_q     <= rate_cnt_d;
         underrun_cnt_q <= underrun_cnt_d;
         x_i_q          <= x_i_d;
         x_q_q          <= x_q_d;
         xd_i_q         <= xd_i_d;
         xd_q_q         <= xd_q_d;
         comb1_i_q      <= comb1_i_d;
         comb1_q_q      <= comb1_q_d;
         comb2_i_q      <= comb2_i_d;
         comb2_q_q      <= comb2_q_d;
         pop_s0_q       <= pop_s0_d;
         pop_s1_q       <= pop_s1_d;
         integ1_i_q     <= integ1_i_d;
         integ1_q_q     <= integ1_q_d;
         integ2_i_q     <= integ2_i_d;
         integ2_q_q     <= integ2_q_d;
         sat_i_q        <= sat_i_d;
         sat_q_q        <= sat_q_d;
         sin_q          <= sin_d;
         cos_q          <= cos_d;
         prod_i_q       <= prod_i_d;
         prod_q_q       <= prod_q_d;
         dac_q          <= dac_d;
      end
   end

endmodule

// File: tb/tb_interp_upconvert.sv
// tb_interp_upconvert
// Directed bench for interp_upconvert (INTERP=3, FIFO_DEPTH=4, PRIME=2,
// two's-complement output build).

module tb_interp_upconvert;

   localparam logic [23:0] A_IN    = 24'h100000;
   localparam logic [19:0] NCO_MAX = 20'h7FFFF;

   logic        dac_clk = 1'b0;
   logic        reset_n;
   logic [23:0] in_i, in_q;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] nco_sin, nco_cos;
   logic [13:0] dac_data;
   logic        running;
   logic [15:0] underrun_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 dac_clk = ~dac_clk;

   interp_upconvert #(.INTERP(3), .FIFO_DEPTH(4), .PRIME(2)) dut (
      .dac_clk      (dac_clk),
      .reset_n      (reset_n),
      .in_i         (in_i),
      .in_q         (in_q),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .nco_sin      (nco_sin),
      .nco_cos      (nco_cos),
      .dac_data     (dac_data),
      .running      (running),
      .underrun_cnt (underrun_cnt)
   );

   task automatic tick();
      @(posedge dac_clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      in_valid = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      tick();
      n_checks++;
      if (dac_data !== 14'd0) $display("[TB] FAIL rst_dac: got %0d want 0", $signed(dac_data)); else n_pass++;
      n_checks++;
      if (running !== 1'b0) $display("[TB] FAIL rst_running: got %b want 0", running); else n_pass++;
      n_checks++;
      if (underrun_cnt !== 16'd0) $display("[TB] FAIL rst_underrun: got %0d want 0", underrun_cnt); else n_pass++;
      n_checks++;
      if (in_ready !== 1'b0) $display("[TB] FAIL rst_ready_low: got %b want 0", in_ready); else n_pass++;
      reset_n = 1'b1;
      tick();
      n_checks++;
      if (in_ready !== 1'b1) $display("[TB] FAIL rst_ready_release: got %b want 1", in_ready); else n_pass++;
      n_checks++;
      if (running !== 1'b0) $display("[TB] FAIL rst_running_release: got %b want 0", running); else n_pass++;
   endtask

   task automatic test_backpressure();
      do_reset();
      in_i = 24'd1000; in_q = 24'd0; nco_cos = 20'd0; nco_sin = 20'd0;
      in_valid = 1'b1;
      for (int e = 1; e <= 18; e++) begin
         tick();
         if (e == 3) begin
            n_checks++;
            if (running !== 1'b1) $display("[TB] FAIL bp_running: got %b want 1", running); else n_pass++;
            n_checks++;
            if (in_ready !== 1'b1) $display("[TB] FAIL bp_ready_3: got %b want 1", in_ready); else n_pass++;
         end
         if (e == 4) begin
            n_checks++;
            if (in_ready !== 1'b0) $display("[TB] FAIL bp_ready_full: got %b want 0", in_ready); else n_pass++;
         end
         if (e == 5) begin
            n_checks++;
            if (in_ready !== 1'b0) $display("[TB] FAIL bp_ready_held: got %b want 0", in_ready); else n_pass++;
            in_valid = 1'b0;
         end
         if (e == 6) begin
            n_checks++;
            if (in_ready !== 1'b1) $display("[TB] FAIL bp_ready_after_pop: got %b want 1", in_ready); else n_pass++;
         end
         if (e == 17) begin
            n_checks++;
            if (underrun_cnt !== 16'd0) $display("[TB] FAIL bp_no_fifth_word: underrun %0d want 0", underrun_cnt); else n_pass++;
         end
         if (e == 18) begin
            n_checks++;
            if (underrun_cnt !== 16'd1) $display("[TB] FAIL bp_first_starve: underrun %0d want 1", underrun_cnt); else n_pass++;
         end
      end
   endtask

   task automatic test_dc_tone();
      do_reset();
      in_i = A_IN; in_q = 24'd0; nco_cos = NCO_MAX; nco_sin = 20'd0;
      in_valid = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (e == 11) begin
            n_checks++;
            if (dac_data !== 14'd0) $display("[TB] FAIL dc_latency: got %0d want 0", $signed(dac_data)); else n_pass++;
         end
         if (e == 12) begin
            n_checks++;
            if (dac_data !== 14'd256) $display("[TB] FAIL dc_step1: got %0d want 256", $signed(dac_data)); else n_pass++;
         end
         if (e == 13) begin
            n_checks++;
            if (dac_data !== 14'd512) $display("[TB] FAIL dc_step2: got %0d want 512", $signed(dac_data)); else n_pass++;
         end
         if (e == 14) begin
            n_checks++;
            if (dac_data !== 14'd768) $display("[TB] FAIL dc_step3: got %0d want 768", $signed(dac_data)); else n_pass++;
         end
         if (e == 20) begin
            n_checks++;
            if (dac_data !== 14'd768) $display("[TB] FAIL dc_settled: got %0d want 768", $signed(dac_data)); else n_pass++;
         end
      end
      nco_cos = 20'd0;
      tick();
      tick();
      n_checks++;
      if (dac_data !== 14'd768) $display("[TB] FAIL nco_align_before: got %0d want 768", $signed(dac_data)); else n_pass++;
      tick();
      n_checks++;
      if (dac_data !== 14'd0) $display("[TB] FAIL nco_align_after: got %0d want 0", $signed(dac_data)); else n_pass++;
      in_i = 24'd0; in_q = A_IN; nco_sin = NCO_MAX;
      for (int e = 0; e < 30; e++) tick();
      n_checks++;
      if (dac_data !== 14'h3D00) $display("[TB] FAIL dc_quadrature: got %0d want -768", $signed(dac_data)); else n_pass++;
   endtask

   task automatic test_saturation();
      in_i = 24'h7FFFFF; in_q = 24'h800000; nco_cos = NCO_MAX; nco_sin = NCO_MAX;
      in_valid = 1'b1;
      for (int e = 0; e < 40; e++) tick();
      n_checks++;
      if (dac_data !== 14'h1FFF) $display("[TB] FAIL sat_pos: got %0d want 8191", $signed(dac_data)); else n_pass++;
      in_i = 24'h800001; in_q = 24'h7FFFFF;
      for (int e = 0; e < 40; e++) tick();
      n_checks++;
      if (dac_data !== 14'h2000) $display("[TB] FAIL sat_neg: got %0d want -8192", $signed(dac_data)); else n_pass++;
   endtask

   task automatic test_underrun();
      int accepted;
      int guard;
      do_reset();
      in_i = A_IN; in_q = 24'd0; nco_cos = NCO_MAX; nco_sin = 20'd0;
      accepted = 0;
      guard    = 0;
      in_valid = 1'b1;
      while (accepted < 10 && guard < 200) begin
         if (in_ready === 1'b1) accepted++;
         tick();
         guard++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (accepted != 10) $display("[TB] FAIL ur_words_accepted: got %0d want 10", accepted); else n_pass++;
      guard = 0;
      while (underrun_cnt == 16'd0 && guard < 200) begin
         tick();
         guard++;
      end
      n_checks++;
      if (underrun_cnt !== 16'd1) $display("[TB] FAIL ur_start: underrun %0d want 1", underrun_cnt); else n_pass++;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 2) begin
            n_checks++;
            if (underrun_cnt !== 16'd1) $display("[TB] FAIL ur_hold: underrun %0d want 1", underrun_cnt); else n_pass++;
         end
         if (k == 3) begin
            n_checks++;
            if (underrun_cnt !== 16'd2) $display("[TB] FAIL ur_second: underrun %0d want 2", underrun_cnt); else n_pass++;
         end
         if (k == 5) begin
            n_checks++;
            if (dac_data !== 14'd768) $display("[TB] FAIL ur_last_full: got %0d want 768", $signed(dac_data)); else n_pass++;
         end
         if (k == 6) begin
            n_checks++;
            if (dac_data !== 14'd512) $display("[TB] FAIL ur_decay1: got %0d want 512", $signed(dac_data)); else n_pass++;
            n_checks++;
            if (underrun_cnt !== 16'd3) $display("[TB] FAIL ur_third: underrun %0d want 3", underrun_cnt); else n_pass++;
         end
         if (k == 7) begin
            n_checks++;
            if (dac_data !== 14'd256) $display("[TB] FAIL ur_decay2: got %0d want 256", $signed(dac_data)); else n_pass++;
         end
         if (k == 8) begin
            n_checks++;
            if (dac_data !== 14'd0) $display("[TB] FAIL ur_decay_zero: got %0d want 0", $signed(dac_data)); else n_pass++;
            n_checks++;
            if (running !== 1'b1) $display("[TB] FAIL ur_running: got %b want 1", running); else n_pass++;
         end
      end
   endtask

   task automatic test_midstream_reset();
      in_i = A_IN; in_q = 24'd0; nco_cos = NCO_MAX; nco_sin = 20'd0;
      in_valid = 1'b1;
      for (int e = 0; e < 20; e++) tick();
      n_checks++;
      if (dac_data !== 14'd768) $display("[TB] FAIL resume_data: got %0d want 768", $signed(dac_data)); else n_pass++;
      reset_n = 1'b0;
      tick();
      n_checks++;
      if (dac_data !== 14'd0) $display("[TB] FAIL mid_rst_dac: got %0d want 0", $signed(dac_data)); else n_pass++;
      n_checks++;
      if (running !== 1'b0) $display("[TB] FAIL mid_rst_running: got %b want 0", running); else n_pass++;
      n_checks++;
      if (underrun_cnt !== 16'd0) $display("[TB] FAIL mid_rst_underrun: got %0d want 0", underrun_cnt); else n_pass++;
      n_checks++;
      if (in_ready !== 1'b0) $display("[TB] FAIL mid_rst_ready: got %b want 0", in_ready); else n_pass++;
      in_valid = 1'b0;
      reset_n  = 1'b1;
      tick();
      n_checks++;
      if (in_ready !== 1'b1) $display("[TB] FAIL mid_rst_ready_release: got %b want 1", in_ready); else n_pass++;
      n_checks++;
      if (dac_data !== 14'd0) $display("[TB] FAIL mid_rst_dac_release: got %0d want 0", $signed(dac_data)); else n_pass++;
   endtask

   // Run every scenario in order, then report
   initial begin
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_i     = 24'd0;
      in_q     = 24'd0;
      nco_sin  = 20'd0;
      nco_cos  = 20'd0;
      test_reset();
      test_backpressure();
      test_dc_tone();
      test_saturation();
      test_underrun();
      test_midstream_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
